// File: rtl/traceback_ctrl.sv
// DTW traceback sequencer: walks the optimal warping path from (tlen,rlen) back to (0,0),
// copying each addressed cell's record from the shared bus into result SRAM.
module traceback_ctrl #(
    parameter int unsigned       ADDR_W    = 6,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [6:0]        MAX_STEPS = 7'd61
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              i_start,
    input  logic [4:0]        i_tlen,
    input  logic [4:0]        i_rlen,
    output logic [4:0]        o_tindex,
    output logic [4:0]        o_rindex,
    output logic              o_outena,
    input  logic [31:0]       i_data,
    input  logic              i_ena0,
    input  logic              i_ena1,
    input  logic              i_ena2,
    output logic              o_sram_wen,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [31:0]       o_sram_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [ADDR_W-1:0] o_len
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_OUT,
        S_WAIT,
        S_FIN,
        S_ERR
    } state_t;

    state_t            state_q;
    logic [4:0]        tlen_q, rlen_q;
    logic [4:0]        tidx_q, ridx_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              outena_q;
    logic              wen_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              busy_q, done_q, err_q;
    logic [ADDR_W-1:0] len_q;

    logic       at_origin, one_hot, off_grid, at_limit, step_ok;
    logic [4:0] tidx_d, ridx_d;

    // Range checks are evaluated before any decrement, so the indices never wrap.
    always_comb begin
        at_origin = (tidx_q == 5'd0) && (ridx_q == 5'd0);
        one_hot   = ({i_ena2, i_ena1, i_ena0} == 3'b001) ||
                    ({i_ena2, i_ena1, i_ena0} == 3'b010) ||
                    ({i_ena2, i_ena1, i_ena0} == 3'b100);
        off_grid  = (i_ena0 && ((tidx_q == 5'd0) || (ridx_q == 5'd0))) ||
                    (i_ena1 && (tidx_q == 5'd0)) ||
                    (i_ena2 && (ridx_q == 5'd0));
        at_limit  = (32'(cnt_q) == 32'(MAX_STEPS));
        step_ok   = one_hot && !off_grid && !at_limit;
        tidx_d    = tidx_q;
        ridx_d    = ridx_q;
        if (i_ena0 || i_ena1) tidx_d = tidx_q - 5'd1;
        if (i_ena0 || i_ena2) ridx_d = ridx_q - 5'd1;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= S_IDLE;
            tlen_q   <= '0;
            rlen_q   <= '0;
            tidx_q   <= '1;
            ridx_q   <= '1;
            cnt_q    <= '0;
            outena_q <= 1'b0;
            wen_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            len_q    <= '0;
        end else begin
            done_q   <= 1'b0;
            wen_q    <= 1'b0;
            outena_q <= 1'b0;
            unique case (state_q)
                S_IDLE, S_FIN, S_ERR: begin
                    if (i_start) begin
                        tlen_q  <= i_tlen;
                        rlen_q  <= i_rlen;
                        err_q   <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_CHECK;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_CHECK: begin
                    if ((tlen_q == 5'd31) || (rlen_q == 5'd31)) begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        len_q   <= cnt_q;
                        state_q <= S_ERR;
                    end else begin
                        tidx_q   <= tlen_q;
                        ridx_q   <= rlen_q;
                        outena_q <= 1'b1;
                        state_q  <= S_OUT;
                    end
                end
                S_OUT: begin
                    wdata_q <= i_data;
                    addr_q  <= BASE_ADDR + cnt_q;
                    wen_q   <= 1'b1;
                    cnt_q   <= cnt_q + ADDR_W'(1);
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (at_origin) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        len_q   <= cnt_q;
                        tidx_q  <= '1;
                        ridx_q  <= '1;
                        state_q <= S_FIN;
                    end else if (step_ok) begin
                        tidx_q   <= tidx_d;
                        ridx_q   <= ridx_d;
                        outena_q <= 1'b1;
                        state_q  <= S_OUT;
                    end else begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        len_q   <= cnt_q;
                        tidx_q  <= '1;
                        ridx_q  <= '1;
                        state_q <= S_ERR;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_tindex     = tidx_q;
    assign o_rindex     = ridx_q;
    assign o_outena     = outena_q;
    assign o_sram_wen   = wen_q;
    assign o_sram_addr  = addr_q;
    assign o_sram_wdata = wdata_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_err        = err_q;
    assign o_len        = len_q;

endmodule
